// File: rtl/burst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : burst_seq_pkg
// Description : Shared types and default widths for the burst sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package burst_seq_pkg;

    // Default beat-counter width and burst-exponent width
    localparam int c_SIZECOUNT = 12;
    localparam int c_SIZEBURST = 8;

    // Sequencer states, explicitly encoded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } burst_state_t;

endpackage : burst_seq_pkg
`default_nettype wire

// File: rtl/burst_end_det.sv
`default_nettype none
// ============================================================================
// Module      : burst_end_det
// Description : Combinational end-of-burst detector. Flags the beat whose
//               index is the last one of a 2^sizeburst-aligned burst.
//               An exponent at or above the counter width means the whole
//               job is one burst, so the detector never fires.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_end_det
    import burst_seq_pkg::*;
#(
    parameter int SIZECOUNT = c_SIZECOUNT,
    parameter int SIZEBURST = c_SIZEBURST
) (
    input  logic [SIZECOUNT-1:0] i_count,
    input  logic [SIZEBURST-1:0] i_sizeburst,
    output logic                 o_burst_end
);

    logic [SIZECOUNT-1:0] w_mask;
    logic                 w_single;

    // Low-order mask of the burst size: bit i set when i < sizeburst
    for (genvar i = 0; i < SIZECOUNT; i++) begin : g_mask_bit
        assign w_mask[i] = (int'(i_sizeburst) > i);
    end

    assign w_single = (int'(i_sizeburst) >= SIZECOUNT);

    // (count+1) mod 2^sizeburst == 0  <=>  the low sizeburst bits are all ones
    always_comb begin
        o_burst_end = 1'b0;
        if (!w_single) begin
            o_burst_end = ((i_count & w_mask) == w_mask);
        end
    end

endmodule : burst_end_det
`default_nettype wire

// File: rtl/burst_seq.sv
`default_nettype none
// ============================================================================
// Module      : burst_seq
// Description : Burst sequencer. Latches a job (length, burst exponent),
//               requests the bus once per burst, and passes the beat
//               handshake through while granted. Flags the last beat of
//               each burst and of the job on out_last.
//               Optional feature macro: BURST_SEQ_ABORT_EN adds an abort
//               input that ends the job early from REQ or XFER.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_seq
    import burst_seq_pkg::*;
#(
    parameter int SIZECOUNT = c_SIZECOUNT,
    parameter int SIZEBURST = c_SIZEBURST
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef BURST_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 start,
    input  logic [SIZECOUNT-1:0] len_m1,
    input  logic [SIZEBURST-1:0] sizeburst,
    output logic                 busy,
    output logic                 done,
    output logic                 req,
    input  logic                 gnt,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [SIZECOUNT-1:0] count
);

    burst_state_t         r_state;
    burst_state_t         w_state_nxt;
    logic [SIZECOUNT-1:0] r_len_m1;
    logic [SIZECOUNT-1:0] r_count;
    logic [SIZEBURST-1:0] r_sizeburst;
    logic                 w_abort;
    logic                 w_xfer;
    logic                 w_beat;
    logic                 w_burst_end;
    logic                 w_job_end;

`ifdef BURST_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // An abort cycle carries no beat on either side of the handshake
    assign w_xfer    = (r_state == XFER) && !w_abort;
    assign w_beat    = w_xfer && in_valid && out_ready;
    assign w_job_end = (r_count == r_len_m1);

    burst_end_det #(
        .SIZECOUNT (SIZECOUNT),
        .SIZEBURST (SIZEBURST)
    ) u_end_det (
        .i_count     (r_count),
        .i_sizeburst (r_sizeburst),
        .o_burst_end (w_burst_end)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Job parameters and beat counter; the counter parks on len_m1 so it never wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len_m1    <= '0;
            r_sizeburst <= '0;
            r_count     <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_len_m1    <= len_m1;
            r_sizeburst <= sizeburst;
            r_count     <= '0;
        end else if (w_beat && !w_job_end) begin
            r_count     <= r_count + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (w_abort) begin
                    w_state_nxt = DONE;
                end else if (gnt) begin
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                if (w_abort) begin
                    w_state_nxt = DONE;
                end else if (w_beat && w_job_end) begin
                    w_state_nxt = DONE;
                end else if (w_beat && w_burst_end) begin
                    w_state_nxt = REQ;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output decode, including the zero-cycle handshake pass-through
    always_comb begin
        busy      = (r_state != IDLE);
        req       = (r_state == REQ);
        done      = (r_state == DONE);
        out_valid = w_xfer && in_valid;
        in_ready  = w_xfer && out_ready;
        out_last  = w_beat && (w_burst_end || w_job_end);
        count     = r_count;
    end

endmodule : burst_seq
`default_nettype wire
